instruction_fetch: RTL
======================

# instruction_fetch

Sequencer that fetches one 16-bit instruction word per request from program memory and presents it on the shared data bus to the instruction register. Holds the program counter, runs a ready/valid-style read handshake with memory, then drives the bus and strobes the instruction register's active-low load. It is the writer side of the instruction register's bus-load interface.

## Interface
- RESET_PC, 16'h0000, program counter value after reset
- TIMEOUT, 8, maximum READ cycles without memReady before abort (≥1, counter 8 bits wide)

- clock  in  1  system clock, all state changes on rising edge
- notReset  in  1  asynchronous, active-low reset
- start  in  1  fetch request, sampled only in IDLE
- notLoadPc  in  1  active-low PC load, sampled only in IDLE
- pcIn  in  16  new PC value for notLoadPc
- memAddr  out  16  memory address, equals pc at all times
- notMemRead  out  1  active-low memory read request
- memReady  in  1  memory data valid, sampled only in READ
- memData  in  16  memory read data, captured when memReady sampled 1
- dataBus  out  16  tri-state; driven with captured word in DRIVE/LOAD/HOLD, 16'hzzzz otherwise
- notIrLoad  out  1  active-low instruction-register load strobe
- pc  out  16  current program counter
- busy  out  1  high in every state except IDLE
- fault  out  1  sticky timeout flag

## Operation
- States: IDLE, READ, DRIVE, LOAD, HOLD.
- IDLE: notMemRead=1, bus z, notIrLoad=1, busy=0.
  - notLoadPc=0 at edge: pc <= pcIn.
  - start=1 at edge: -> READ, fault <= 0, wait counter <= 0.
  - Both at same edge: pc loaded and fetch proceeds from pcIn.
- READ: notMemRead=0, memAddr=pc.
  - memReady=1 at edge: latch memData -> DRIVE.
  - else counter+1; when counter reaches TIMEOUT-1 and memReady=0: fault <= 1, -> IDLE, pc unchanged.
- DRIVE: bus driven with latched word, notIrLoad=1 (setup cycle), -> LOAD.
- LOAD: bus driven, notIrLoad=0; on exit pc <= pc+1 (16-bit wrap, FFFF -> 0000), -> HOLD.
- HOLD: bus driven, notIrLoad=1 (hold cycle), -> IDLE.
- notLoadPc and start ignored while busy=1.
- notMemRead deasserted in all states except READ.

## Timing
- Reset (async, immediate, no clock needed): pc=RESET_PC, notMemRead=1, dataBus=z, notIrLoad=1, busy=0, fault=0, state IDLE, latched word 0.
- Reset mid-operation: bus released and strobes deasserted combinationally with notReset=0; in-flight fetch discarded.
- start sampled at edge N: READ for cycle N..N+1, notMemRead low after edge N.
- memReady sampled 1 at edge M (M ≥ N+1): DRIVE M..M+1, LOAD M+1..M+2, HOLD M+2..M+3, IDLE from M+3.
- Instruction register captures at edge M+2; bus stable one full cycle before and after that edge.
- pc increments at edge M+2.
- Zero-wait fetch: start edge to busy=0 is 4 cycles.
- Timeout: memReady never high → fault=1 and busy=0 after edge N+TIMEOUT; memReady=1 on that same edge wins (normal fetch, no fault).
- fault remains 1 until reset or next accepted start.

## Test plan
- Reset: hold notReset=0 mid-clock → pc=0000, notMemRead=1, dataBus=zzzz, notIrLoad=1, busy=0, fault=0 without a clock edge.
- Zero-wait fetch: pc=0000, memData=F0F0, memReady=1 always, start pulse → memAddr=0000, notMemRead low 1 cycle, bus=F0F0 for 3 cycles, notIrLoad low exactly 1 cycle (the middle), IR outputs decode F0F0, pc=0001, busy low 4 cycles after start.
- Wait states: memReady rises 3 cycles after start, memData=1234 → bus=1234 only after ready, total 6 cycles, pc+1, fault=0.
- Timeout: TIMEOUT=8, memReady=0 → fault=1 and busy=0 after 8 READ cycles, pc unchanged, bus never driven, notIrLoad never low; next start clears fault.
- PC load and wrap: notLoadPc=0, pcIn=FFFF with start in same cycle → memAddr=FFFF, after fetch pc=0000; notLoadPc pulsed while busy → ignored.
- Reset during LOAD: notReset=0 while notIrLoad=0 → bus z and notIrLoad=1 immediately, pc=RESET_PC (not incremented).

Source files
------------

// File: rtl/instruction_fetch.sv
// instruction_fetch
//   Fetches one 16-bit instruction word per request from program memory and
//   presents it on the shared data bus, strobing the instruction register's
//   active-low load in the middle of a three-cycle bus window.
//
// Ports
//   clock, notReset     : system clock (rising edge), async active-low reset
//   start               : fetch request (IDLE only)
//   notLoadPc, pcIn     : active-low PC load and its value (IDLE only)
//   memAddr             : memory address, always equal to pc
//   notMemRead          : active-low read request, low only in READ
//   memReady, memData   : memory handshake (READ only)
//   dataBus             : tri-state bus, driven in DRIVE/LOAD/HOLD
//   notIrLoad           : active-low IR load strobe, low only in LOAD
//   pc                  : program counter
//   busy                : high in every state except IDLE
//   fault               : sticky read-timeout flag, cleared by the next start
module instruction_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          TIMEOUT  = 8
) (
    input  logic        clock,
    input  logic        notReset,
    input  logic        start,
    input  logic        notLoadPc,
    input  logic [15:0] pcIn,
    output logic [15:0] memAddr,
    output logic        notMemRead,
    input  logic        memReady,
    input  logic [15:0] memData,
    output logic [15:0] dataBus,
    output logic        notIrLoad,
    output logic [15:0] pc,
    output logic        busy,
    output logic        fault
);

    typedef enum logic [2:0] {IDLE, READ, DRIVE, LOAD, HOLD} state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t      state, state_next;
    logic [15:0] word;
    logic [7:0]  wait_cnt;
    logic        drive;

    // State register
    always_ff @(posedge clock or negedge notReset) begin
        if (!notReset) state <= IDLE;
        else           state <= state_next;
    end

    // Next state and decoded outputs
    always_comb begin
        state_next = state;
        notMemRead = 1'b1;
        notIrLoad  = 1'b1;
        busy       = 1'b1;
        drive      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_next = READ;
            end
            READ: begin
                notMemRead = 1'b0;
                // Ready on the final wait edge still wins over the timeout.
                if (memReady)                   state_next = DRIVE;
                else if (wait_cnt == WAIT_LAST) state_next = IDLE;
            end
            DRIVE: begin
                drive      = 1'b1;
                state_next = LOAD;
            end
            LOAD: begin
                drive      = 1'b1;
                notIrLoad  = 1'b0;
                state_next = HOLD;
            end
            HOLD: begin
                drive      = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: pc, captured word, wait counter, fault flag
    always_ff @(posedge clock or negedge notReset) begin
        if (!notReset) begin
            pc       <= RESET_PC;
            word     <= 16'h0000;
            wait_cnt <= 8'h00;
            fault    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!notLoadPc) pc <= pcIn;
                    if (start) begin
                        fault    <= 1'b0;
                        wait_cnt <= 8'h00;
                    end
                end
                READ: begin
                    if (memReady)                   word     <= memData;
                    else if (wait_cnt == WAIT_LAST) fault    <= 1'b1;
                    else                            wait_cnt <= wait_cnt + 8'h01;
                end
                LOAD:    pc <= pc + 16'h0001;
                default: ;
            endcase
        end
    end

    assign memAddr = pc;
    // State resets asynchronously, so the bus is released as soon as
    // notReset falls without a separate gate.
    assign dataBus = drive ? word : 16'hzzzz;

endmodule
